// File: rtl/sdram_read_seg.sv
// Full-page SDRAM read engine: ACTIVE -> READ -> BST -> PRE per segment, splitting
// requests at page end and continuing in the next row (and next bank on row wrap).
module sdram_read_seg #(
    parameter int DATA_W  = 16,
    parameter int BANK_W  = 2,
    parameter int ROW_W   = 13,
    parameter int COL_W   = 9,
    parameter int LEN_W   = 16,
    parameter int CAS_LAT = 3,
    parameter int TRCD    = 2,
    parameter int TRP     = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            rd_en,
    input  logic [BANK_W+ROW_W+COL_W-1:0]   rd_addr,
    input  logic [LEN_W-1:0]                rd_len,
    output logic                            rd_busy,
    output logic                            rd_done,
    output logic                            rd_valid,
    output logic [DATA_W-1:0]               rd_data,
    output logic [3:0]                      sdram_cmd,
    output logic [BANK_W-1:0]               sdram_ba,
    output logic [ROW_W-1:0]                sdram_a,
    input  logic [DATA_W-1:0]               sdram_dq_in
);
    // state     | meaning
    // IDLE      | waiting for rd_en
    // ACT       | ACTIVE on the bus this cycle
    // WAIT_TRCD | counting out tRCD
    // RD        | READ on the bus this cycle
    // BURST     | data streaming, BST issued, waiting out CAS latency
    // PRE       | PRECHARGE on the bus this cycle
    // WAIT_TRP  | counting out tRP
    // DONE      | rd_done pulse

    localparam int AW   = BANK_W + ROW_W + COL_W;
    localparam int PAGE = 2 ** COL_W;
    localparam int SW   = COL_W + 1;
    localparam int MW   = (LEN_W > SW) ? LEN_W : SW;
    localparam int BMAX = PAGE + CAS_LAT;
    localparam int TMAX = (TRCD > TRP) ? TRCD : TRP;
    localparam int CNT_MAX = (BMAX > TMAX) ? BMAX : TMAX;
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam int CW = CNT_W + 1;

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_BST = 4'b0110;
    localparam logic [3:0] CMD_PRE = 4'b0010;

    localparam logic [ROW_W-1:0] A10_CLR   = ~(ROW_W'(1) << 10);
    localparam logic [CNT_W-1:0] TRCD_END = CNT_W'((TRCD > 1) ? TRCD - 2 : 0);
    localparam logic [CNT_W-1:0] TRP_END  = CNT_W'((TRP > 1) ? TRP - 2 : 0);
    localparam logic [CW-1:0]    CL_W     = CW'(CAS_LAT);

    typedef enum logic [2:0] {IDLE, ACT, WAIT_TRCD, RD, BURST, PRE, WAIT_TRP, DONE} state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [BANK_W-1:0]   bank;
    logic [ROW_W-1:0]    row;
    logic [COL_W-1:0]    col;
    logic [LEN_W-1:0]    rem;
    logic [SW-1:0]       seg;

    function automatic logic [SW-1:0] seg_len(input logic [LEN_W-1:0] r, input logic [COL_W-1:0] c);
        logic [MW-1:0] room;
        logic [MW-1:0] rr;
        room = MW'(PAGE) - MW'(c);
        rr   = MW'(r);
        seg_len = (rr < room) ? SW'(rr) : SW'(room);
    endfunction

    logic [CW-1:0]          cnt1, cnt2, seg_w;
    logic [LEN_W-1:0]       rem_next;
    logic [BANK_W+ROW_W-1:0] next_br;
    logic                   rd_issue, trp_exit, dq_win;

    always_comb begin
        cnt1     = {1'b0, cnt} + CW'(1);
        cnt2     = {1'b0, cnt} + CW'(2);
        seg_w    = CW'(seg);
        rem_next = rem - LEN_W'(seg);
        next_br  = {bank, row} + (BANK_W + ROW_W)'(1);
        rd_issue = ((state == ACT) && (TRCD == 1)) || ((state == WAIT_TRCD) && (cnt == TRCD_END));
        trp_exit = ((state == PRE) && (TRP == 1)) || ((state == WAIT_TRP) && (cnt == TRP_END));
        // cycle R+1+cnt carries a valid DQ word when CAS_LAT <= cnt+1 < CAS_LAT+seg
        dq_win   = (state == BURST) && (cnt1 >= CL_W) && (cnt1 < seg_w + CL_W);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bank      <= '0;
            row       <= '0;
            col       <= '0;
            rem       <= '0;
            seg       <= '0;
            rd_busy   <= 1'b0;
            rd_done   <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            sdram_cmd <= CMD_NOP;
            sdram_ba  <= '0;
            sdram_a   <= '0;
        end else begin
            sdram_cmd <= CMD_NOP;
            rd_done   <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            cnt       <= cnt + CNT_W'(1);

            if (dq_win) begin
                rd_valid <= 1'b1;
                rd_data  <= sdram_dq_in;
            end

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (rd_en) begin
                        bank    <= rd_addr[AW-1 -: BANK_W];
                        row     <= rd_addr[COL_W +: ROW_W];
                        col     <= rd_addr[COL_W-1:0];
                        rem     <= rd_len;
                        seg     <= seg_len(rd_len, rd_addr[COL_W-1:0]);
                        rd_busy <= 1'b1;
                        if (rd_len == '0) begin
                            state   <= DONE;
                            rd_done <= 1'b1;
                        end else begin
                            state     <= ACT;
                            sdram_cmd <= CMD_ACT;
                            sdram_ba  <= rd_addr[AW-1 -: BANK_W];
                            sdram_a   <= rd_addr[COL_W +: ROW_W];
                        end
                    end
                end
                ACT: begin
                    cnt <= '0;
                    if (!rd_issue) state <= WAIT_TRCD;
                end
                WAIT_TRCD: ;
                RD: begin
                    state <= BURST;
                    cnt   <= '0;
                    if (seg == SW'(1)) sdram_cmd <= CMD_BST;
                end
                BURST: begin
                    // BST is sent even for a full page so the device does not wrap
                    if (cnt2 == seg_w) sdram_cmd <= CMD_BST;
                    if (cnt2 == seg_w + CL_W) begin
                        state     <= PRE;
                        cnt       <= '0;
                        sdram_cmd <= CMD_PRE;
                        sdram_ba  <= bank;
                        sdram_a   <= {ROW_W{1'b1}} & A10_CLR;
                    end
                end
                PRE: begin
                    cnt <= '0;
                    if (!trp_exit) state <= WAIT_TRP;
                end
                WAIT_TRP: ;
                DONE: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    rd_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase

            if (rd_issue) begin
                state     <= RD;
                cnt       <= '0;
                sdram_cmd <= CMD_RD;
                sdram_ba  <= bank;
                sdram_a   <= ROW_W'(col) & A10_CLR;
            end

            if (trp_exit) begin
                rem <= rem_next;
                cnt <= '0;
                if (rem_next == '0) begin
                    state   <= DONE;
                    rd_done <= 1'b1;
                end else begin
                    {bank, row} <= next_br;
                    col       <= '0;
                    seg       <= seg_len(rem_next, '0);
                    state     <= ACT;
                    sdram_cmd <= CMD_ACT;
                    sdram_ba  <= next_br[ROW_W +: BANK_W];
                    sdram_a   <= next_br[ROW_W-1:0];
                end
            end
        end
    end
endmodule

// File: doc/sdram_read_seg.md
Name: sdram_read_seg

Overview:
- Parametrised SDRAM read engine: ACTIVE -> READ (full-page mode) -> BURST TERMINATE -> PRECHARGE.
- Generalised in data/address widths, CAS latency, tRCD and tRP.
- Accepts request lengths beyond one page: splits automatically at column-end and continues in the next row, and in the next bank on row wrap.
- Sits between the SDRAM arbiter (request/command mux) and the read FIFO.

Parameters:
- DATA_W, 16, SDRAM DQ width
- BANK_W, 2, bank address bits
- ROW_W, 13, row bits; also the SDRAM A-bus width (ROW_W >= COL_W+2)
- COL_W, 9, column bits (page = 2^COL_W words)
- LEN_W, 16, request length width
- CAS_LAT, 3, CAS latency; legal values 2 or 3
- TRCD, 2, ACTIVE-to-READ cycles (>=1)
- TRP, 2, PRECHARGE-to-next-ACTIVE/done cycles (>=1)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- rd_en  in  1  request strobe; sampled only when rd_busy=0
- rd_addr  in  BANK_W+ROW_W+COL_W  start address, {bank,row,col}
- rd_len  in  LEN_W  number of words
- rd_busy  out  1  high from the cycle after acceptance through the rd_done cycle
- rd_done  out  1  one-cycle pulse at request completion
- rd_valid  out  1  rd_data holds a read word
- rd_data  out  DATA_W  read word, zero when rd_valid=0
- sdram_cmd  out  4  {cs_n,ras_n,cas_n,we_n}
- sdram_ba  out  BANK_W  bank address
- sdram_a  out  ROW_W  address bus
- sdram_dq_in  in  DATA_W  DQ input

Behaviour:
- Command encodings: NOP 4'b0111, ACTIVE 0011, READ 0101, BST 0110, PRE 0010.
- All outputs are registered.
- Reset values: sdram_cmd=NOP, sdram_ba=0, sdram_a=0, rd_busy=0, rd_done=0, rd_valid=0, rd_data=0. Reset mid-operation returns the block to IDLE immediately; no further commands are issued.
- States: IDLE, ACT, WAIT_TRCD, RD, BURST, PRE, WAIT_TRP, DONE.
- Acceptance (cycle 0): IDLE with rd_en=1. The block latches bank/row/col and sets rem = rd_len.
  - If rem=0: go to DONE. rd_done pulses at cycle 1 and no command is issued.
- Segment length: seg = min(rem, 2^COL_W - col).
- Per segment, with cycle A = the ACTIVE cycle (A = 1 for the first segment):
  - A: ACTIVE, ba=bank, a=row.
  - A+TRCD: READ, ba=bank, a=col zero-extended, A10=0.
  - R = A+TRCD. At R+seg: BST.
  - At R+seg+CAS_LAT: PRE, ba=bank, a=all ones except A10=0 (single-bank precharge).
  - All other cycles: NOP.
- Data capture:
  - DQ is valid on the bus at cycles R+CAS_LAT .. R+CAS_LAT+seg-1.
  - DQ is registered once, so rd_valid is high at R+CAS_LAT+1 .. R+CAS_LAT+seg.
- End of segment, at P+TRP where P = PRE cycle:
  - rem -= seg. If rem=0, rd_done pulses in that cycle and rd_busy falls next cycle.
  - Otherwise that cycle is the next segment's ACTIVE with col=0 and row+1.
  - Row overflow wraps to row 0, bank+1. Bank overflow wraps to bank 0.
  - rd_valid is low during the inter-segment gap.
- cycle counter: width sized for max(TRCD, TRP, 2^COL_W+CAS_LAT). Cleared on every state entry.
- rd_en while busy is ignored, with no queueing.
- rd_en in the rd_done cycle is ignored. The earliest new acceptance is the cycle after rd_done.
- BST is issued even when seg = 2^COL_W, to stop page wrap.

Test Plan:
- Defaults; rd_addr={2'd1,13'd5,9'd8}, len=4, accepted at c0 -> ACTIVE c1 (ba=1,a=5); READ c3 (a=8); BST c7; PRE c10; rd_valid c7..c10 carrying DQ from c6..c9; rd_done c12; rd_busy c1..c12.
- col=508, len=8 -> segment 1: 4 words, PRE c10; ACTIVE row 6 at c12; READ c14 col 0; BST c18; 8 total rd_valid with a gap; a single rd_done at c23.
- Bank 3, row 8191, col 510, len 4 -> second ACTIVE has ba=0, a=0; 4 valids total.
- len=0 -> no non-NOP command, rd_done at c1, rd_valid never high.
- col=0, len=512 -> exactly 512 consecutive rd_valid; BST at R+512; no split. Repeat with CAS_LAT=2: PRE one cycle earlier.
- rd_en pulsed at c5 during a request -> ignored. rst_n low at c8 -> sdram_cmd=NOP, rd_valid=0 immediately; a request after release behaves as scenario 1.
